scan_mux: RTL
=============

Name: scan_mux

Overview:
- Parametrised, registered N-channel multiplexer with an active-low enable.
- Two modes: manual (the select input chooses the channel) and auto-scan (the channel steps 0..N-1, holding each for DWELL cycles).
- Sits in front of shared display/serial paths that need one channel at a time, and reports which channel is currently presented on the output.

Parameters:
- N, 4, number of input channels (2..2**SW).
- W, 1, bits per channel.
- SW, 2, select/index width; N <= 2**SW.
- DWELL, 4, cycles each channel is held in scan mode (>=1).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- G  input  1  active-low enable; 1 = disabled.
- M  input  1  mode; 0 = manual, 1 = auto-scan.
- C  input  SW  manual channel select.
- X  input  N*W  packed channel data; channel k = X[k*W +: W].
- Y  output  W  registered selected data.
- S  output  SW  channel index currently presented on Y.
- V  output  1  Y valid.
- E  output  1  one-cycle pulse when scan wraps from N-1 to 0.

Behaviour:
- Reset: RST_N low asynchronously forces:
  - Y = 0, S = 0, V = 0, E = 0
  - dwell counter = 0
  - state = OFF
- States:
  - OFF (G = 1)
  - MAN (G = 0, M = 0)
  - SCAN (G = 0, M = 1)
  - The next state is decoded every cycle from G and M. G = 1 overrides M.
- Output register rule: every edge, S and Y load together, with Y <= X slice of the new S value. Y and S are therefore always mutually consistent. Latency is one clock from X/C to Y.
- OFF:
  - Y <= 0, V <= 0, E <= 0, counter <= 0.
  - S holds its last value.
- MAN:
  - S <= C, Y <= channel C, V <= 1, E <= 0, counter <= 0.
  - If C >= N: S <= C, Y <= 0, V <= 0.
- SCAN, entry edge (previous state not SCAN): S <= 0, counter <= 0, Y <= channel 0, V <= 1, E <= 0.
- SCAN, steady state:
  - If counter == DWELL-1: counter <= 0 and S <= S+1. If S == N-1, S <= 0 instead and E <= 1 for that cycle only.
  - Otherwise: counter <= counter+1 and S holds.
  - Y always tracks the live X of the current channel, not a snapshot.
- DWELL = 1: S advances on every edge while in SCAN.
- Mode and enable changes:
  - M 1->0 mid-dwell: MAN takes effect on the next edge and the counter clears.
  - Returning to SCAN always restarts at channel 0.
  - G rising in any state: OFF on the next edge.
- Counter width: clog2(DWELL) bits, minimum 1. It never exceeds DWELL-1.
- Out of range: no X bits beyond N*W are ever read.

Test Plan:
- Reset, then G = 1, M = 0, X = 4'b1010 -> Y = 0, V = 0, S = 0 on every edge. Assert RST_N low mid-scan -> all outputs 0 immediately, without waiting for a clock edge.
- MAN (N = 4, W = 1): X = 4'b0001, C = 0 -> next edge Y = 1, S = 0, V = 1. Then C = 1 -> next edge Y = 0, S = 1. Then X = 4'b0010 -> next edge Y = 1.
- SCAN (DWELL = 4): X = 4'b0101, M = 1 -> S = 0,0,0,0,1,1,1,1,2,... and Y = 1,1,1,1,0,0,0,0,1,... E = 1 exactly on the edge where S goes 3->0 (cycle 17 after entry), otherwise 0.
- Mode switch mid-scan at S = 2 with counter = 1: drop M with C = 3 -> next edge S = 3, Y = X[3]. Raise M again -> S = 0, with a full 4-cycle dwell on channel 0.
- N = 3, SW = 2, W = 8: MAN with C = 3 -> Y = 0, V = 0. SCAN -> S wraps 2->0 and never visits 3.
- DWELL = 1, N = 4: S = 0,1,2,3,0,... on consecutive edges, with E high every 4th cycle.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel multiplexer with an active-low enable.
// In manual mode the select input picks the channel. In auto-scan mode the
// channel steps 0..N-1 and each one is held for DWELL cycles. S always names
// the channel whose data is currently on Y.
module scan_mux #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            G,
    input  logic            M,
    input  logic [SW-1:0]   C,
    input  logic [N*W-1:0]  X,
    output logic [W-1:0]    Y,
    output logic [SW-1:0]   S,
    output logic            V,
    output logic            E
);

    // The counter needs at least one bit, even when DWELL is 1.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [SW-1:0]   s_next;
    logic            e_next;
    logic [W-1:0]    chan_data;
    logic            in_range;

    // Decode the mode from G and M, and work out the next channel index, dwell count and wrap pulse.
    always_comb begin
        state_next = ST_MAN;
        s_next     = S;
        cnt_next   = '0;
        e_next     = 1'b0;

        if (G) begin
            state_next = ST_OFF;
        end else if (M) begin
            state_next = ST_SCAN;
        end

        case (state_next)
            ST_OFF: begin
                s_next = S;
            end
            ST_MAN: begin
                s_next = C;
            end
            ST_SCAN: begin
                if (state != ST_SCAN) begin
                    s_next   = '0;
                    cnt_next = '0;
                end else if (cnt == CW'(DWELL - 1)) begin
                    cnt_next = '0;
                    if (S == SW'(N - 1)) begin
                        s_next = '0;
                        e_next = 1'b1;
                    end else begin
                        s_next = S + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                s_next = S;
            end
        endcase
    end

    // Select the slice for the new index. Only the N real channels are decoded, so no bits past N*W are ever read.
    always_comb begin
        chan_data = '0;
        in_range  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (s_next == SW'(k)) begin
                chan_data = X[k*W +: W];
                in_range  = 1'b1;
            end
        end
    end

    // Load the state, the counter, S and Y together so that Y always matches the channel named by S.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_OFF;
            cnt   <= '0;
            S     <= '0;
            Y     <= '0;
            V     <= 1'b0;
            E     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            S     <= s_next;
            E     <= e_next;
            if (state_next == ST_OFF) begin
                Y <= '0;
                V <= 1'b0;
            end else begin
                Y <= chan_data;
                V <= in_range;
            end
        end
    end

endmodule
